// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite transfer constants and exclusive data-phase kinds
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_NORM,
        DP_XRD,
        DP_XWR_OK,
        DP_XWR_FAIL
    } dp_kind_t;

endpackage

// File: rtl/ahbl_excl_res_table.sv
// rtl/ahbl_excl_res_table.sv - per-master reservation slots with clear-over-set priority
module ahbl_excl_res_table #(
    parameter int N_MASTERS = 2,
    parameter int W_SLOT    = 1,
    parameter int W_GRAN    = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_SLOT-1:0] i_lk_slot,
    input  logic [W_GRAN-1:0] i_lk_gran,
    output logic              o_lk_hit,
    input  logic              i_set_en,
    input  logic [W_SLOT-1:0] i_set_slot,
    input  logic [W_GRAN-1:0] i_set_gran,
    input  logic              i_gclr_en,
    input  logic [W_GRAN-1:0] i_gclr_gran,
    input  logic              i_sclr_en,
    input  logic [W_SLOT-1:0] i_sclr_slot
);

    logic [N_MASTERS-1:0] r_valid;
    logic [W_GRAN-1:0]    r_addr [N_MASTERS];
    logic [N_MASTERS-1:0] w_nxt_valid;
    logic [W_GRAN-1:0]    w_nxt_addr [N_MASTERS];

    always_comb begin
        o_lk_hit = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (i_lk_slot == W_SLOT'(k))
                o_lk_hit = r_valid[k] && (r_addr[k] == i_lk_gran);
        end
    end

    // The granule clear is judged against the post-set slot contents, so a
    // same-cycle completion and a conflicting write resolve to "cleared".
    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            logic w_set;
            logic w_gclr;
            w_set          = i_set_en && (i_set_slot == W_SLOT'(k));
            w_nxt_addr[k]  = w_set ? i_set_gran : r_addr[k];
            w_nxt_valid[k] = w_set | r_valid[k];
            w_gclr         = i_gclr_en && (w_nxt_addr[k] == i_gclr_gran);
            if (w_gclr || (i_sclr_en && (i_sclr_slot == W_SLOT'(k))))
                w_nxt_valid[k] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        r_addr <= w_nxt_addr;
        if (rst)
            r_valid <= '0;
        else
            r_valid <= w_nxt_valid;
    end

endmodule

// File: rtl/ahbl_excl_monitor.sv
// rtl/ahbl_excl_monitor.sv - AHB-Lite exclusive monitor: hexokay generation and failing-write suppression
module ahbl_excl_monitor
    import ahbl_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int GRAN_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int W_SLOT = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int W_GRAN = W_ADDR - GRAN_LOG2;

    logic              w_ap;
    logic              w_slot_ok;
    logic [W_SLOT-1:0] w_slot;
    logic [W_GRAN-1:0] w_gran;
    logic              w_lk_hit;
    dp_kind_t          w_kind;
    logic              w_set_en;
    logic              w_gclr_en;
    logic              w_sclr_en;

    dp_kind_t          r_dp_kind;
    logic [W_SLOT-1:0] r_dp_slot;
    logic [W_GRAN-1:0] r_dp_gran;
    logic              r_dp_slot_ok;

    assign w_ap      = src_htrans[1] & src_hready;
    assign w_slot_ok = src_hmaster < 8'(N_MASTERS);
    assign w_slot    = src_hmaster[W_SLOT-1:0];
    assign w_gran    = src_haddr[W_ADDR-1:GRAN_LOG2];

    always_comb begin
        w_kind = DP_IDLE;
        if (w_ap) begin
            if (!src_hexcl)                  w_kind = DP_NORM;
            else if (!src_hwrite)            w_kind = DP_XRD;
            else if (w_slot_ok && w_lk_hit)  w_kind = DP_XWR_OK;
            else                             w_kind = DP_XWR_FAIL;
        end
    end

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = (w_kind == DP_XWR_FAIL) ? HTRANS_IDLE : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;
    assign src_hrdata    = dst_hrdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_kind    <= DP_IDLE;
            r_dp_slot    <= '0;
            r_dp_gran    <= '0;
            r_dp_slot_ok <= 1'b0;
        end else if (src_hready) begin
            r_dp_kind    <= w_kind;
            r_dp_slot    <= w_slot;
            r_dp_gran    <= w_gran;
            r_dp_slot_ok <= w_slot_ok;
        end
    end

    // A failed exclusive write never reached the slave, so its data phase is answered locally.
    always_comb begin
        src_hready_resp = dst_hready_resp;
        src_hresp       = dst_hresp;
        src_hexokay     = ~rst & dst_hready_resp & ~dst_hresp &
                          ((r_dp_kind == DP_XRD) || (r_dp_kind == DP_XWR_OK));
        if (r_dp_kind == DP_XWR_FAIL) begin
            src_hready_resp = 1'b1;
            src_hresp       = 1'b0;
            src_hexokay     = 1'b0;
        end
    end

    assign w_set_en  = (r_dp_kind == DP_XRD) && r_dp_slot_ok && dst_hready_resp && !dst_hresp;
    assign w_gclr_en = w_ap && src_hwrite && ((w_kind == DP_NORM) || (w_kind == DP_XWR_OK));
    assign w_sclr_en = w_slot_ok && ((w_kind == DP_XWR_OK) || (w_kind == DP_XWR_FAIL));

    ahbl_excl_res_table #(
        .N_MASTERS (N_MASTERS),
        .W_SLOT    (W_SLOT),
        .W_GRAN    (W_GRAN)
    ) u_res_table (
        .clk         (clk),
        .rst         (rst),
        .i_lk_slot   (w_slot),
        .i_lk_gran   (w_gran),
        .o_lk_hit    (w_lk_hit),
        .i_set_en    (w_set_en),
        .i_set_slot  (r_dp_slot),
        .i_set_gran  (r_dp_gran),
        .i_gclr_en   (w_gclr_en),
        .i_gclr_gran (w_gran),
        .i_sclr_en   (w_sclr_en),
        .i_sclr_slot (w_slot)
    );

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// tb/tb_ahbl_excl_monitor.sv - scoreboard bench for the exclusive-access monitor
module tb_ahbl_excl_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_hready;
    logic        src_hready_resp;
    logic        src_hresp;
    logic [31:0] src_haddr;
    logic        src_hwrite;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize;
    logic [2:0]  src_hburst;
    logic [3:0]  src_hprot;
    logic        src_hmastlock;
    logic [31:0] src_hwdata;
    logic [31:0] src_hrdata;
    logic        src_hexcl;
    logic [7:0]  src_hmaster;
    logic        src_hexokay;
    logic        dst_hready;
    logic        dst_hready_resp;
    logic        dst_hresp;
    logic [31:0] dst_haddr;
    logic        dst_hwrite;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize;
    logic [2:0]  dst_hburst;
    logic [3:0]  dst_hprot;
    logic        dst_hmastlock;
    logic [31:0] dst_hwdata;
    logic [31:0] dst_hrdata;

    typedef struct {
        logic xok;
        logic resp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    assign src_hready = src_hready_resp;

    always #5 clk = ~clk;

    ahbl_excl_monitor dut (
        .clk             (clk),
        .rst             (rst),
        .src_hready      (src_hready),
        .src_hready_resp (src_hready_resp),
        .src_hresp       (src_hresp),
        .src_haddr       (src_haddr),
        .src_hwrite      (src_hwrite),
        .src_htrans      (src_htrans),
        .src_hsize       (src_hsize),
        .src_hburst      (src_hburst),
        .src_hprot       (src_hprot),
        .src_hmastlock   (src_hmastlock),
        .src_hwdata      (src_hwdata),
        .src_hrdata      (src_hrdata),
        .src_hexcl       (src_hexcl),
        .src_hmaster     (src_hmaster),
        .src_hexokay     (src_hexokay),
        .dst_hready      (dst_hready),
        .dst_hready_resp (dst_hready_resp),
        .dst_hresp       (dst_hresp),
        .dst_haddr       (dst_haddr),
        .dst_hwrite      (dst_hwrite),
        .dst_htrans      (dst_htrans),
        .dst_hsize       (dst_hsize),
        .dst_hburst      (dst_hburst),
        .dst_hprot       (dst_hprot),
        .dst_hmastlock   (dst_hmastlock),
        .dst_hwdata      (dst_hwdata),
        .dst_hrdata      (dst_hrdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One non-pipelined transfer: address phase, then data phase until HREADY.
    task automatic xfer(input string tag, input logic [7:0] m, input logic [31:0] a,
                        input logic w, input logic x, input logic err, input logic exp_ok);
        logic  supp;
        logic [31:0] rd;
        exp_t  e;
        int    waited;
        supp = x & w & ~exp_ok;
        src_hmaster = m;
        src_haddr   = a;
        src_hwrite  = w;
        src_hexcl   = x;
        src_htrans  = 2'b10;
        e.xok  = exp_ok;
        e.resp = err & ~supp;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ".dst_htrans"}, 32'(dst_htrans), supp ? 32'h0 : 32'h2);
        chk({tag, ".dst_haddr"}, dst_haddr, a);
        cyc();
        src_htrans = 2'b00;
        src_hwdata = $urandom;
        rd         = $urandom;
        dst_hrdata = rd;
        if (supp) begin
            dst_hready_resp = 1'b0;
        end else if (err) begin
            dst_hready_resp = 1'b0;
            dst_hresp       = 1'b1;
            @(negedge clk);
            chk({tag, ".err1_ready"}, 32'(src_hready_resp), 32'h0);
            cyc();
            dst_hready_resp = 1'b1;
        end
        waited = 0;
        @(negedge clk);
        while (!src_hready_resp && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, ".ready"}, 32'(src_hready_resp), 32'h1);
        e = sb.pop_front();
        chk({tag, ".hexokay"}, 32'(src_hexokay), 32'(e.xok));
        chk({tag, ".hresp"}, 32'(src_hresp), 32'(e.resp));
        if (!w && !supp)
            chk({tag, ".hrdata"}, src_hrdata, rd);
        if (w && !supp)
            chk({tag, ".hwdata"}, dst_hwdata, src_hwdata);
        cyc();
        dst_hready_resp = 1'b1;
        dst_hresp       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        src_haddr = '0; src_hwrite = 1'b0; src_htrans = 2'b00; src_hsize = 3'd2;
        src_hburst = 3'd0; src_hprot = 4'h3; src_hmastlock = 1'b0; src_hwdata = '0;
        src_hexcl = 1'b0; src_hmaster = '0;
        dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst.hexokay", 32'(src_hexokay), 32'h0);
        chk("rst.hresp", 32'(src_hresp), 32'h0);
        chk("rst.ready", 32'(src_hready_resp), 32'h1);
        cyc();
        rst = 1'b0;
        cyc();

        xfer("t1_xrd",   8'd0, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t1_xwr",   8'd0, 32'h1004, 1'b1, 1'b1, 1'b0, 1'b1);
        xfer("t1_again", 8'd0, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0);

        xfer("t2_xwr",   8'd1, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);

        xfer("t3_xrd",   8'd0, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t3_wr",    8'd1, 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer("t3_xwr",   8'd0, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b0);

        xfer("t4_xrd0",  8'd0, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t4_xrd1",  8'd1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t4_xwr1",  8'd1, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
        xfer("t4_xwr0",  8'd0, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b0);

        xfer("t5_xrd",   8'd0, 32'h5000, 1'b0, 1'b1, 1'b1, 1'b0);
        xfer("t5_xwr",   8'd0, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0);

        xfer("t6_rd",    8'd1, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer("t6_xwr_m5", 8'd5, 32'h6000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reservation of another granule survives an unrelated write.
        xfer("t7_xrd",   8'd1, 32'h7008, 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t7_wr",    8'd0, 32'h7000, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer("t7_xwr",   8'd1, 32'h700c, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset lands on the data phase of an exclusive read.
        src_hmaster = 8'd0; src_haddr = 32'h8000; src_hwrite = 1'b0;
        src_hexcl = 1'b1; src_htrans = 2'b10;
        cyc();
        src_htrans = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        chk("t8_rst.hexokay", 32'(src_hexokay), 32'h0);
        chk("t8_rst.hresp", 32'(src_hresp), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        xfer("t8_xwr",   8'd0, 32'h8000, 1'b1, 1'b1, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
